// File: rtl/serial_deserializer.sv
// Serial-to-parallel word assembler, LSB first, with a one-deep output holding register.
// Optional trailing even-parity bit per word when SERIAL_DESERIALIZER_PARITY_EN is defined.
//
// Parameters:
//   WIDTH      data bits per word (2..32)
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   d          serial data bit
//   d_valid    qualifies d; one bit accepted per edge
//   sync_clr   synchronous discard of the partial word
//   q          assembled word
//   q_valid    q holds an unconsumed word
//   q_ready    consumer takes q when q_valid is high
//   overrun    sticky: a completed word was dropped
//   parity_err parity mismatch on the word in q (tied 0 without parity)
module serial_deserializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d,
  input  logic             d_valid,
  input  logic             sync_clr,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  input  logic             q_ready,
  output logic             overrun,
  output logic             parity_err
);

`ifdef SERIAL_DESERIALIZER_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif

  // The shift register holds every bit of a word except the one
  // accepted on the completing edge, which is taken straight from d.
  localparam int SW   = NBITS - 1;
  localparam int CW   = $clog2(NBITS);
  localparam int LAST = NBITS - 1;

  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic [SW-1:0]    sr;
  logic [SW-1:0]    sr_nxt;
  logic [SW-1:0]    sr_shift;
  logic             accept;
  logic             done;
  logic             load;
  logic             drop;
  logic             consume;
  logic [WIDTH-1:0] word;

  assign accept  = d_valid & ~sync_clr;
  assign done    = accept & (cnt == CW'(LAST));
  assign consume = q_valid & q_ready;
  assign load    = done & (~q_valid | q_ready);
  assign drop    = done & q_valid & ~q_ready;

  // Right shift with d entering at the top; the first bit of a word
  // ends up in bit 0 once the register is full.
  assign sr_shift = SW'({d, sr} >> 1);

`ifdef SERIAL_DESERIALIZER_PARITY_EN
  logic word_perr;

  // Final edge carries the parity bit; the data is already in sr.
  assign word      = sr;
  assign word_perr = ^{sr, d};
`else
  assign word = {d, sr};
`endif

  always_comb begin
    cnt_nxt = cnt;
    sr_nxt  = sr;
    if (sync_clr) begin
      cnt_nxt = '0;
      sr_nxt  = '0;
    end else if (d_valid) begin
      if (done) begin
        cnt_nxt = '0;
        sr_nxt  = '0;
      end else begin
        cnt_nxt = cnt + CW'(1);
        sr_nxt  = sr_shift;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      sr  <= '0;
    end else begin
      cnt <= cnt_nxt;
      sr  <= sr_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q       <= '0;
      q_valid <= 1'b0;
    end else if (load) begin
      q       <= word;
      q_valid <= 1'b1;
    end else if (consume) begin
      q_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end
  end

`ifdef SERIAL_DESERIALIZER_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity_err <= 1'b0;
    end else if (load) begin
      parity_err <= word_perr;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_deserializer.sv
// Scoreboard bench for serial_deserializer (WIDTH=8).
// Expected words are queued at stimulus time; a monitor checks them when consumed.
module tb_serial_deserializer;

  localparam int W = 8;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic         clk;
  logic         rst;
  logic         d;
  logic         d_valid;
  logic         sync_clr;
  logic [W-1:0] q;
  logic         q_valid;
  logic         q_ready;
  logic         overrun;
  logic         parity_err;

  serial_deserializer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .d         (d),
    .d_valid   (d_valid),
    .sync_clr  (sync_clr),
    .q         (q),
    .q_valid   (q_valid),
    .q_ready   (q_ready),
    .overrun   (overrun),
    .parity_err(parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] w;
    logic         pe;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // Inputs change 2 time units after a rising edge, so the falling edge
  // sees stable inputs and outputs of the upcoming consume edge.
  always @(negedge clk) begin
    if (rst === 1'b1 && q_valid === 1'b1 && q_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: got word %0h expected none", q);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_q", 32'(q), 32'(e.w));
        chk("sb_perr", 32'(parity_err), 32'(e.pe));
      end
    end
  end

  task automatic send_word(input logic [W-1:0] w, input bit pflip,
                           input bit gaps, input bit idle_chk,
                           input bit rdy_last);
    logic b;
    for (int i = 0; i < NB; i++) begin
      if (i < W) b = w[i];
      else       b = (^w) ^ pflip;
      if (rdy_last && i == NB - 1) q_ready = 1'b1;
      d       = b;
      d_valid = 1'b1;
      tick();
      d_valid = 1'b0;
      d       = 1'b0;
      if (i < NB - 1) begin
        if (idle_chk) chk("early_valid", 32'(q_valid), 32'd0);
        if (gaps) repeat ((i % 3) + 1) tick();
      end
    end
  endtask

  task automatic consume;
    q_ready = 1'b1;
    tick();
    q_ready = 1'b0;
    chk("consumed_valid", 32'(q_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b0;
    d        = 1'b0;
    d_valid  = 1'b0;
    sync_clr = 1'b0;
    q_ready  = 1'b0;
    repeat (2) tick();
    chk("rst_q", 32'(q), 32'd0);
    chk("rst_valid", 32'(q_valid), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_perr", 32'(parity_err), 32'd0);
    rst = 1'b1;
    tick();

    // Back-to-back A5
    sb.push_back('{8'hA5, 1'b0});
    send_word(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("b2b_q", 32'(q), 32'hA5);
    chk("b2b_valid", 32'(q_valid), 32'd1);
    chk("b2b_overrun", 32'(overrun), 32'd0);
    consume();

    // A5 with 1..3 cycle gaps
    sb.push_back('{8'hA5, 1'b0});
    send_word(8'hA5, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("gap_q", 32'(q), 32'hA5);
    chk("gap_valid", 32'(q_valid), 32'd1);
    consume();

    // Overrun: A5 held, 3C dropped
    sb.push_back('{8'hA5, 1'b0});
    send_word(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
    send_word(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovr_q", 32'(q), 32'hA5);
    chk("ovr_valid", 32'(q_valid), 32'd1);
    chk("ovr_flag", 32'(overrun), 32'd1);
    consume();
    chk("ovr_sticky", 32'(overrun), 32'd1);

    // Reset mid-word
    d       = 1'b1;
    d_valid = 1'b1;
    repeat (3) tick();
    d_valid = 1'b0;
    d       = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    chk("midrst_q", 32'(q), 32'd0);
    chk("midrst_valid", 32'(q_valid), 32'd0);
    chk("midrst_overrun", 32'(overrun), 32'd0);
    chk("midrst_perr", 32'(parity_err), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    sb.push_back('{8'h3C, 1'b0});
    send_word(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("postrst_q", 32'(q), 32'h3C);
    chk("postrst_valid", 32'(q_valid), 32'd1);
    consume();

    // Completion on the consume edge
    sb.push_back('{8'hA5, 1'b0});
    send_word(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
    sb.push_back('{8'h3C, 1'b0});
    send_word(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("same_q", 32'(q), 32'h3C);
    chk("same_valid", 32'(q_valid), 32'd1);
    chk("same_overrun", 32'(overrun), 32'd0);
    tick();
    q_ready = 1'b0;
    chk("same_drain", 32'(q_valid), 32'd0);

    // sync_clr drops a partial word and the bit on its edge
    d       = 1'b1;
    d_valid = 1'b1;
    repeat (3) tick();
    sync_clr = 1'b1;
    tick();
    sync_clr = 1'b0;
    d_valid  = 1'b0;
    d        = 1'b0;
    chk("clr_valid", 32'(q_valid), 32'd0);
    sb.push_back('{8'h5A, 1'b0});
    send_word(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("clr_q", 32'(q), 32'h5A);
    sync_clr = 1'b1;
    tick();
    sync_clr = 1'b0;
    chk("clr_hold_q", 32'(q), 32'h5A);
    chk("clr_hold_valid", 32'(q_valid), 32'd1);
    consume();

`ifdef SERIAL_DESERIALIZER_PARITY_EN
    sb.push_back('{8'hA5, 1'b0});
    send_word(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("par_ok", 32'(parity_err), 32'd0);
    consume();
    sb.push_back('{8'hA5, 1'b1});
    send_word(8'hA5, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("par_bad", 32'(parity_err), 32'd1);
    chk("par_bad_q", 32'(q), 32'hA5);
    consume();
`else
    chk("par_tied", 32'(parity_err), 32'd0);
`endif

    repeat (2) tick();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_deserializer.md
SERIAL_DESERIALIZER -- requirements
Module: serial_deserializer

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 8, meaning the number of data bits per word (legal range 2..32).
REQ-002 The block SHALL provide port clk  input  1  rising-edge clock for all state.
REQ-003 The block SHALL provide port rst  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL provide port d  input  1  serial data bit, driven by the upstream D flip-flop q output.
REQ-005 The block SHALL provide port d_valid  input  1  qualifies d; a bit is accepted on each rising clk edge with d_valid=1.
REQ-006 The block SHALL provide port sync_clr  input  1  synchronous discard of the partially assembled word.
REQ-007 The block SHALL provide port q  output  WIDTH  assembled parallel word.
REQ-008 The block SHALL provide port q_valid  output  1  q holds an unconsumed word.
REQ-009 The block SHALL provide port q_ready  input  1  consumer accepts q on an edge where q_valid=1 and q_ready=1.
REQ-010 The block SHALL provide port overrun  output  1  sticky flag: a completed word was dropped.
REQ-011 The block SHALL provide port parity_err  output  1  parity mismatch on the word currently in q.

Function
REQ-012 Accepted bits SHALL be assembled LSB first: the first accepted bit of a word lands in q[0], the last in q[WIDTH-1].
REQ-013 The block SHALL have no input backpressure; every bit with d_valid=1 is accepted.
REQ-014 The block SHALL run a bit counter 0..WIDTH-1 (0..WIDTH with PARITY_EN); d_valid=0 cycles SHALL hold the counter and shift register unchanged.
REQ-015 The word SHALL complete on the edge that accepts its final bit, with the counter returning to 0 on that same edge.
REQ-016 On completion with q_valid=0, q SHALL load the full word and q_valid SHALL rise on that same edge (zero extra latency).
REQ-017 q_valid SHALL stay high, with q stable, until an edge with q_ready=1, and SHALL then clear unless a new word completes on that edge.
REQ-018 If a word completes on the same edge that q is consumed, the new word SHALL load, q_valid SHALL stay 1, and overrun SHALL NOT set.
REQ-019 If a word completes while q_valid=1 and q_ready=0, the new word SHALL be dropped, q SHALL keep the old word, and overrun SHALL set and hold until reset.
REQ-020 sync_clr=1 SHALL zero the counter and shift register on that edge and discard any bit presented on that edge, without affecting q, q_valid, overrun or parity_err.
REQ-021 q_ready SHALL be ignored while q_valid=0.

Reset
REQ-022 rst=0 SHALL immediately, without a clock, force q=0, q_valid=0, overrun=0, parity_err=0, counter=0 and shift register=0.
REQ-023 Reset asserted mid-word SHALL discard the partial word; the first bit accepted after release SHALL be bit 0 of a new word.
REQ-024 The first rising edge with rst=1 SHALL operate normally.

Configuration
REQ-025 With macro SERIAL_DESERIALIZER_PARITY_EN defined, each word SHALL be followed by one extra accepted parity bit; completion, per REQ-015 to REQ-019, SHALL occur on the parity-bit edge.
REQ-026 With SERIAL_DESERIALIZER_PARITY_EN defined, parity_err SHALL load with q and be 1 when the XOR of the WIDTH data bits and the parity bit is 1 (even parity); the word SHALL still be delivered.
REQ-027 Without SERIAL_DESERIALIZER_PARITY_EN, words SHALL be exactly WIDTH bits, and parity_err SHALL be present and tied to 0.

Verification (WIDTH=8)
REQ-028 The bench SHALL cover: bits 1,0,1,0,0,1,0,1 on 8 consecutive edges with d_valid=1 and q_ready=0 -> q=8'hA5 and q_valid=1 at the 8th edge.
REQ-029 The bench SHALL cover: the same bits with d_valid=0 gaps of 1 to 3 cycles between them -> q=8'hA5 at the edge of the 8th accepted bit, with no earlier q_valid.
REQ-030 The bench SHALL cover: 8'hA5 held with q_ready=0, then 8'h3C fully shifted in -> q=8'hA5, q_valid=1, overrun=1; then q_ready=1 for one edge -> q_valid=0.
REQ-031 The bench SHALL cover: q=8'hA5 pending, with q_ready=1 on the final-bit edge of 8'h3C -> q=8'h3C, q_valid=1, overrun=0.
REQ-032 The bench SHALL cover: 3 bits shifted in, rst pulsed low between edges, then 8'h3C shifted in -> outputs 0 during reset, then q=8'h3C with no corruption.
REQ-033 The bench SHALL cover, with PARITY_EN: 8'hA5 followed by parity 0 -> parity_err=0; followed by parity 1 -> parity_err=1 and q=8'hA5.
